// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM command path: ramp state encoding
// and default timing constants.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // One PWM period at 50 MHz.
  localparam int CYCLES_1MS_50MHZ = 50000;
  localparam int RAMP_STEP_DEF    = 500;
  localparam int DEAD_TICKS_DEF   = 2;

endpackage

// File: rtl/pwm_period_tick.sv
// Period tick generator: counts 0..i_cycles_in_1ms and pulses o_period_tick
// on the last count, so the period is i_cycles_in_1ms+1 clocks. Shared with
// the PWM generator so both see the same period boundary.
module pwm_period_tick #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [COUNTER_WIDTH-1:0] i_cycles_in_1ms,
  output logic                     o_period_tick
);

  logic [COUNTER_WIDTH-1:0] r_cnt;

  // Free-running period counter; the >= guard recovers if the period shrinks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt >= i_cycles_in_1ms) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_period_tick = (r_cnt == i_cycles_in_1ms);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Motor command stage: accepts speed/direction commands and slews the PWM
// duty word toward the target by at most RAMP_STEP per period tick. A
// direction reversal drains duty to zero and waits DEAD_TICKS periods
// before the direction pin changes.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16,
  parameter int RAMP_STEP     = RAMP_STEP_DEF,
  parameter int DEAD_TICKS    = DEAD_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] CYCLES_IN_1MS,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COUNTER_WIDTH-1:0] cmd_duty,
  input  logic                     cmd_dir,
  input  logic                     cmd_brake,
  output logic [COUNTER_WIDTH-1:0] pwm_duty,
  output logic                     dir_o,
  output logic                     at_target,
  output logic                     period_tick
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W:0]   STEP_X  = (W+1)'(RAMP_STEP);
  localparam logic [7:0]   DEAD_LD = 8'(DEAD_TICKS);

  state_t         r_state;
  logic [W-1:0]   r_duty;
  logic [W-1:0]   r_target;
  logic           r_dir;
  logic           r_pdir;
  logic [7:0]     r_dead;
  logic           r_ready;
  logic           r_at;

  state_t         w_state;
  logic [W-1:0]   w_duty;
  logic [W-1:0]   w_target;
  logic           w_dir;
  logic           w_pdir;
  logic [7:0]     w_dead;
  logic           w_tick;
  logic           w_accept;
  logic [W-1:0]   w_cmd_duty;

  // One bounded step from duty toward tgt, evaluated one bit wider so the
  // sum and difference can never wrap.
  function automatic logic [W-1:0] f_step(input logic [W-1:0] duty,
                                          input logic [W-1:0] tgt);
    logic [W:0] d, t, s;
    d = {1'b0, duty};
    t = {1'b0, tgt};
    if (d < t) begin
      s = d + STEP_X;
      f_step = (s >= t) ? tgt : s[W-1:0];
    end else if ((d - t) <= STEP_X) begin
      f_step = tgt;
    end else begin
      s = d - STEP_X;
      f_step = s[W-1:0];
    end
  endfunction

  // Saturate a commanded duty to the period length.
  function automatic logic [W-1:0] f_clamp(input logic [W-1:0] duty,
                                           input logic [W-1:0] lim);
    f_clamp = (duty > lim) ? lim : duty;
  endfunction

  pwm_period_tick #(
    .COUNTER_WIDTH(W)
  ) u_tick (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cycles_in_1ms(CYCLES_IN_1MS),
    .o_period_tick  (w_tick)
  );

  assign w_accept   = cmd_valid && r_ready;
  assign w_cmd_duty = f_clamp(cmd_duty, CYCLES_IN_1MS);

  // Next-state: the tick step uses the old target, then an accepted command
  // overrides target/state (a brake overrides the step as well).
  always_comb begin
    w_state  = r_state;
    w_duty   = r_duty;
    w_target = r_target;
    w_dir    = r_dir;
    w_pdir   = r_pdir;
    w_dead   = r_dead;

    case (r_state)
      ST_RAMP: begin
        if (w_tick) begin
          w_duty = f_step(r_duty, r_target);
          if (w_duty == r_target) w_state = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_tick) begin
          w_duty = f_step(r_duty, '0);
          if (w_duty == '0) begin
            w_state = ST_DEAD;
            w_dead  = DEAD_LD;
          end
        end
      end
      ST_DEAD: begin
        if (w_tick) begin
          w_dead = r_dead - 8'd1;
          if (r_dead <= 8'd1) begin
            w_dead  = '0;
            w_dir   = r_pdir;
            w_state = (r_target == '0) ? ST_IDLE : ST_RAMP;
          end
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      if (cmd_brake) begin
        w_duty   = '0;
        w_target = '0;
        w_state  = ST_IDLE;
      end else begin
        w_target = w_cmd_duty;
        if (cmd_dir != r_dir) begin
          w_state = ST_DRAIN;
          w_pdir  = cmd_dir;
        end else if (w_cmd_duty != w_duty) begin
          w_state = ST_RAMP;
        end else begin
          w_state = ST_IDLE;
        end
      end
    end
  end

  // State and registered outputs; ready/at_target follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_dir    <= 1'b0;
      r_pdir   <= 1'b0;
      r_dead   <= '0;
      r_ready  <= 1'b0;
      r_at     <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_duty   <= w_duty;
      r_target <= w_target;
      r_dir    <= w_dir;
      r_pdir   <= w_pdir;
      r_dead   <= w_dead;
      r_ready  <= (w_state == ST_IDLE) || (w_state == ST_RAMP);
      r_at     <= (w_state == ST_IDLE);
    end
  end

  assign cmd_ready   = r_ready;
  assign pwm_duty    = r_duty;
  assign dir_o       = r_dir;
  assign at_target   = r_at;
  assign period_tick = w_tick;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios with literal expectations plus
// randomized commands, all checked every cycle against a behavioural model.
module tb_pwm_duty_ramp;

  localparam int C    = 1500;
  localparam int STEP = 500;
  localparam int DT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cyc;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_duty;
  logic        cmd_dir;
  logic        cmd_brake;
  logic [15:0] pwm_duty;
  logic        dir_o;
  logic        at_target;
  logic        period_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(
    .COUNTER_WIDTH(16),
    .RAMP_STEP    (STEP),
    .DEAD_TICKS   (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .CYCLES_IN_1MS(cyc),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_duty     (cmd_duty),
    .cmd_dir      (cmd_dir),
    .cmd_brake    (cmd_brake),
    .pwm_duty     (pwm_duty),
    .dir_o        (dir_o),
    .at_target    (at_target),
    .period_tick  (period_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt, m_duty, m_target, m_dead;
  bit m_dir, m_pdir, m_rev, m_ready, m_at;
  bit m_live = 1'b0;

  function automatic int approach(input int d, input int t);
    if (d < t) return (d + STEP < t) ? d + STEP : t;
    return (d - t <= STEP) ? t : d - STEP;
  endfunction

  always @(posedge clk) begin : model
    bit tick, acc;
    int nd, req;
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_target = 0; m_dead = 0;
      m_dir = 0; m_pdir = 0; m_rev = 0; m_ready = 0; m_at = 1;
      m_live = 1'b1;
    end else if (m_live) begin
      tick  = (m_cnt == C);
      m_cnt = tick ? 0 : m_cnt + 1;
      acc   = cmd_valid && m_ready;
      nd    = m_duty;
      if (tick) begin
        if (m_dead > 0) begin
          m_dead--;
          if (m_dead == 0) begin
            m_dir = m_pdir;
            m_rev = 0;
          end
        end else if (m_rev) begin
          nd = approach(m_duty, 0);
          if (nd == 0) m_dead = DT;
        end else begin
          nd = approach(m_duty, m_target);
        end
      end
      m_duty = nd;
      if (acc) begin
        if (cmd_brake) begin
          m_duty = 0; m_target = 0;
        end else begin
          req      = int'(cmd_duty);
          m_target = (req > C) ? C : req;
          if (cmd_dir != m_dir) begin
            m_rev  = 1;
            m_pdir = cmd_dir;
          end
        end
      end
      m_ready = !(m_rev || m_dead > 0);
      m_at    = !m_rev && (m_dead == 0) && (m_duty == m_target);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("duty_vs_model", pwm_duty, m_duty);
      check("dir_vs_model", dir_o, m_dir);
      check("at_target_vs_model", at_target, m_at);
      check("ready_vs_model", cmd_ready, m_ready);
      check("tick_vs_model", period_tick, (m_cnt == C));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int d, input bit dir, input bit brk);
    cmd_valid = 1'b1;
    cmd_duty  = d[15:0];
    cmd_dir   = dir;
    cmd_brake = brk;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_brake = 1'b0;
  endtask

  // Wait through the next tick edge; return at the negedge after it.
  task automatic wait_tick();
    int k = 0;
    while (period_tick !== 1'b1 && k < 2 * C) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * C) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no period_tick within %0d cycles", 2 * C);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int gap, r;
    rst = 1'b1; cyc = 16'(C);
    cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = 1'b0; cmd_brake = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_duty", pwm_duty, 0);
    check("rst_dir", dir_o, 0);
    check("rst_at", at_target, 1);
    check("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Period length
    wait_tick();
    k = 0;
    while (period_tick !== 1'b1 && k < 2 * C) begin
      @(negedge clk);
      k++;
    end
    check("period_len", k + 1, C + 1);
    @(negedge clk);

    // Ramp up to 1200
    send(1200, 1'b0, 1'b0);
    wait_tick(); check("ramp_500", pwm_duty, 500); check("ramp_at0", at_target, 0);
    wait_tick(); check("ramp_1000", pwm_duty, 1000);
    repeat (100) @(negedge clk);
    check("ramp_hold", pwm_duty, 1000);
    wait_tick(); check("ramp_1200", pwm_duty, 1200); check("ramp_at1", at_target, 1);

    // Clamp
    send(60000, 1'b0, 1'b0);
    wait_tick(); check("clamp_1500", pwm_duty, 1500); check("clamp_at", at_target, 1);
    wait_tick(); check("clamp_stay", pwm_duty, 1500);

    // Reversal from 1000
    send(1000, 1'b0, 1'b0);
    wait_tick(); check("rev_pre_1000", pwm_duty, 1000);
    send(700, 1'b1, 1'b0);
    check("rev_ready0", cmd_ready, 0);
    wait_tick(); check("rev_500", pwm_duty, 500);
    wait_tick(); check("rev_0", pwm_duty, 0); check("rev_dir_still0", dir_o, 0);
    wait_tick(); check("dead1_duty", pwm_duty, 0); check("dead1_dir", dir_o, 0);
    wait_tick(); check("dead2_duty", pwm_duty, 0); check("rev_dir1", dir_o, 1);
    wait_tick(); check("rev_up_500", pwm_duty, 500);
    wait_tick(); check("rev_up_700", pwm_duty, 700); check("rev_at", at_target, 1);

    // Brake, then brake mid-ramp
    send(0, 1'b1, 1'b1);
    check("brake0_duty", pwm_duty, 0); check("brake0_dir", dir_o, 1);
    send(5000, 1'b1, 1'b0);
    wait_tick(); check("b_ramp_500", pwm_duty, 500);
    wait_tick(); check("b_ramp_1000", pwm_duty, 1000);
    repeat (10) @(negedge clk);
    send(1234, 1'b0, 1'b1);
    check("brake_duty", pwm_duty, 0);
    check("brake_dir", dir_o, 1);
    check("brake_at", at_target, 1);

    // Accept coincident with tick
    send(3000, 1'b1, 1'b0);
    wait_tick(); check("co_500", pwm_duty, 500);
    wait_tick(); check("co_1000", pwm_duty, 1000);
    k = 0;
    while (period_tick !== 1'b1 && k < 2 * C) begin
      @(negedge clk);
      k++;
    end
    send(1100, 1'b1, 1'b0);
    check("co_1500", pwm_duty, 1500); check("co_at0", at_target, 0);
    wait_tick(); check("co_1100", pwm_duty, 1100); check("co_at1", at_target, 1);

    // Randomized commands and occasional resets
    repeat (24) begin
      gap = $urandom_range(0, 1600);
      repeat (gap) @(negedge clk);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end else begin
        send($urandom_range(0, 2000), 1'($urandom_range(0, 1)), (r < 3));
      end
    end
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
